// File: rtl/game_pkg.sv
// Shared types and helpers for the game-round timer: display codes, FSM states,
// and binary/BCD conversion for the two-digit count.
package game_pkg;

  localparam logic [6:0] BLANK_CODE       = 7'h7F;
  localparam int         MAX_SECS_DEFAULT = 99;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  function automatic bcd_t bin_to_bcd(input logic [6:0] bin);
    bcd_t r;
    r.tens = 4'(bin / 7'd10);
    r.ones = 4'(bin % 7'd10);
    return r;
  endfunction

  function automatic logic [6:0] bcd_to_bin(input bcd_t b);
    return (7'(b.tens) * 7'd10) + 7'(b.ones);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..TICKS_PER_SEC-1 while enabled and flags the
// wrap cycle. The count is retained while disabled; clear restarts it at 0.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int           W    = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] r_count;

  assign tick = enable && !clear && (r_count == LAST);

  // Cycle counter with wrap at LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (r_count == LAST) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + W'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/round_timer.sv
// Game-round countdown timer driving tens/ones digit decoders.
// Optional macro ROUND_TIMER_BLINK_EN blinks "00" while expired.
module round_timer
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int BLINK_TICKS   = 12_500_000,
  parameter int MAX_SECS      = MAX_SECS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [6:0] load_secs,
  output logic [6:0] tens_code,
  output logic [6:0] ones_code,
  output logic       running,
  output logic       expired,
  output logic [6:0] secs_left
);

  localparam logic [6:0] MAX_V = 7'(MAX_SECS);

  state_e     r_state, w_state_nxt;
  bcd_t       r_cnt, w_cnt_nxt, w_load_bcd, w_dec_bcd;
  logic [6:0] w_load_clamped;
  logic       w_sec_tick, w_presc_clear, w_enter_exp, w_expired_nxt, w_blank_exp;
  logic [6:0] w_tens_code_nxt, w_ones_code_nxt;
  logic [6:0] r_tens_code, r_ones_code, r_secs_left;
  logic       r_running, r_expired;

  assign w_load_clamped = (load_secs > MAX_V) ? MAX_V : load_secs;
  assign w_load_bcd     = bin_to_bcd(w_load_clamped);
  assign w_dec_bcd.ones = (r_cnt.ones == 4'd0) ? 4'd9 : (r_cnt.ones - 4'd1);
  assign w_dec_bcd.tens = (r_cnt.ones == 4'd0) ? (r_cnt.tens - 4'd1) : r_cnt.tens;
  assign w_expired_nxt  = w_enter_exp && !r_expired;

  tick_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_sec_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (r_state == RUN),
    .clear  (w_presc_clear),
    .tick   (w_sec_tick)
  );

  // Next state and count; abort beats start beats pause
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_presc_clear = 1'b0;
    w_enter_exp   = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (start) begin
      w_presc_clear = 1'b1;
      w_cnt_nxt     = w_load_bcd;
      if (w_load_clamped == 7'd0) begin
        w_state_nxt = EXPIRED;
        w_enter_exp = 1'b1;
      end else begin
        w_state_nxt = RUN;
      end
    end else begin
      case (r_state)
        IDLE: w_state_nxt = IDLE;
        RUN: begin
          if (w_sec_tick) begin
            w_cnt_nxt = w_dec_bcd;
          end else begin
            w_cnt_nxt = r_cnt;
          end
          // A wrap coinciding with pause still decrements before freezing
          if (w_sec_tick && (w_dec_bcd == '0)) begin
            w_state_nxt = EXPIRED;
            w_enter_exp = 1'b1;
          end else if (pause) begin
            w_state_nxt = PAUSE;
          end else begin
            w_state_nxt = RUN;
          end
        end
        PAUSE: begin
          if (!pause) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = PAUSE;
          end
        end
        EXPIRED: w_state_nxt = EXPIRED;
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef ROUND_TIMER_BLINK_EN
  logic w_blink_tick, r_blink_phase, w_blink_phase_nxt;

  tick_prescaler #(.TICKS_PER_SEC(BLINK_TICKS)) u_blink_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (r_state == EXPIRED),
    .clear  (w_enter_exp),
    .tick   (w_blink_tick)
  );

  // Blink phase: "00" first on every entry to EXPIRED
  always_comb begin
    if (w_state_nxt != EXPIRED) begin
      w_blink_phase_nxt = 1'b0;
    end else if (w_enter_exp) begin
      w_blink_phase_nxt = 1'b0;
    end else if (w_blink_tick) begin
      w_blink_phase_nxt = !r_blink_phase;
    end else begin
      w_blink_phase_nxt = r_blink_phase;
    end
  end

  // Blink phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_phase <= 1'b0;
    end else begin
      r_blink_phase <= w_blink_phase_nxt;
    end
  end

  assign w_blank_exp = w_blink_phase_nxt;
`else
  assign w_blank_exp = 1'b0;
`endif

  // Digit codes derived from next count so they change on the counting edge
  always_comb begin
    w_tens_code_nxt = BLANK_CODE;
    w_ones_code_nxt = BLANK_CODE;
    case (w_state_nxt)
      IDLE: begin
        w_tens_code_nxt = BLANK_CODE;
        w_ones_code_nxt = BLANK_CODE;
      end
      RUN, PAUSE: begin
        w_tens_code_nxt = (w_cnt_nxt.tens == 4'd0) ? BLANK_CODE : {3'b000, w_cnt_nxt.tens};
        w_ones_code_nxt = {3'b000, w_cnt_nxt.ones};
      end
      EXPIRED: begin
        w_tens_code_nxt = w_blank_exp ? BLANK_CODE : {3'b000, w_cnt_nxt.tens};
        w_ones_code_nxt = w_blank_exp ? BLANK_CODE : {3'b000, w_cnt_nxt.ones};
      end
      default: begin
        w_tens_code_nxt = BLANK_CODE;
        w_ones_code_nxt = BLANK_CODE;
      end
    endcase
  end

  // FSM state, count and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_tens_code <= BLANK_CODE;
      r_ones_code <= BLANK_CODE;
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
      r_secs_left <= 7'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tens_code <= w_tens_code_nxt;
      r_ones_code <= w_ones_code_nxt;
      r_running   <= (w_state_nxt == RUN) || (w_state_nxt == PAUSE);
      r_expired   <= w_expired_nxt;
      r_secs_left <= bcd_to_bin(w_cnt_nxt);
    end
  end

  assign tens_code = r_tens_code;
  assign ones_code = r_ones_code;
  assign running   = r_running;
  assign expired   = r_expired;
  assign secs_left = r_secs_left;

endmodule

// File: tb/tb_round_timer.sv
// Directed-vector bench for round_timer with TICKS_PER_SEC=4 and BLINK_TICKS=3.
module tb_round_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] load_secs = 7'd0;
  logic [6:0] tens_code, ones_code, secs_left;
  logic       running, expired;

  int n_vec = 0;
  int n_err = 0;

  round_timer #(.TICKS_PER_SEC(4), .BLINK_TICKS(3), .MAX_SECS(99)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .load_secs (load_secs),
    .tens_code (tens_code),
    .ones_code (ones_code),
    .running   (running),
    .expired   (expired),
    .secs_left (secs_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [6:0] v);
    load_secs = v;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic check_disp(input string tag, input logic [6:0] t, input logic [6:0] o,
                            input logic [6:0] s, input logic run, input logic exp);
    check({tag, ".tens"}, 32'(tens_code), 32'(t));
    check({tag, ".ones"}, 32'(ones_code), 32'(o));
    check({tag, ".secs"}, 32'(secs_left), 32'(s));
    check({tag, ".run"},  32'(running),   32'(run));
    check({tag, ".exp"},  32'(expired),   32'(exp));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check_disp("rst_hold", 7'h7F, 7'h7F, 7'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(10);
    check_disp("rst_idle", 7'h7F, 7'h7F, 7'd0, 1'b0, 1'b0);

    // Load 12: one decrement every 4 cycles, expiry at 48
    pulse_start(7'd12);
    check_disp("l12_e0", 7'd1, 7'd2, 7'd12, 1'b1, 1'b0);
    cycles(3);
    check_disp("l12_e3", 7'd1, 7'd2, 7'd12, 1'b1, 1'b0);
    cycles(1);
    check_disp("l12_e4", 7'd1, 7'd1, 7'd11, 1'b1, 1'b0);
    cycles(4);
    check_disp("l12_e8", 7'd1, 7'd0, 7'd10, 1'b1, 1'b0);
    cycles(4);
    check_disp("l12_e12", 7'h7F, 7'd9, 7'd9, 1'b1, 1'b0);
    cycles(35);
    check_disp("l12_e47", 7'h7F, 7'd1, 7'd1, 1'b1, 1'b0);
    cycles(1);
    check_disp("l12_e48", 7'd0, 7'd0, 7'd0, 1'b0, 1'b1);
    cycles(1);
    check_disp("l12_e49", 7'd0, 7'd0, 7'd0, 1'b0, 1'b0);
    cycles(2);
`ifdef ROUND_TIMER_BLINK_EN
    check_disp("blink_e51", 7'h7F, 7'h7F, 7'd0, 1'b0, 1'b0);
    cycles(2);
    check_disp("blink_e53", 7'h7F, 7'h7F, 7'd0, 1'b0, 1'b0);
    cycles(1);
    check_disp("blink_e54", 7'd0, 7'd0, 7'd0, 1'b0, 1'b0);
`else
    check_disp("steady_e51", 7'd0, 7'd0, 7'd0, 1'b0, 1'b0);
    cycles(3);
    check_disp("steady_e54", 7'd0, 7'd0, 7'd0, 1'b0, 1'b0);
`endif

    // Clamp and zero load
    pulse_start(7'd120);
    check_disp("clamp", 7'd9, 7'd9, 7'd99, 1'b1, 1'b0);
    pulse_start(7'd0);
    check_disp("zero_e0", 7'd0, 7'd0, 7'd0, 1'b0, 1'b1);
    cycles(1);
    check_disp("zero_e1", 7'd0, 7'd0, 7'd0, 1'b0, 1'b0);

    // Pause: 6 counted cycles, freeze, then 2 more to the next decrement
    pulse_start(7'd5);
    cycles(4);
    check_disp("p_e4", 7'h7F, 7'd4, 7'd4, 1'b1, 1'b0);
    cycles(1);
    pause = 1'b1;
    cycles(20);
    check_disp("p_held", 7'h7F, 7'd4, 7'd4, 1'b1, 1'b0);
    pause = 1'b0;
    cycles(2);
    check_disp("p_resume1", 7'h7F, 7'd4, 7'd4, 1'b1, 1'b0);
    cycles(1);
    check_disp("p_resume2", 7'h7F, 7'd3, 7'd3, 1'b1, 1'b0);

    // Abort at 3 seconds left
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    check_disp("abort", 7'h7F, 7'h7F, 7'd0, 1'b0, 1'b0);
    cycles(1);
    check_disp("abort_idle", 7'h7F, 7'h7F, 7'd0, 1'b0, 1'b0);

    // Abort wins over start
    pulse_start(7'd7);
    check_disp("l7", 7'h7F, 7'd7, 7'd7, 1'b1, 1'b0);
    abort = 1'b1;
    pulse_start(7'd30);
    abort = 1'b0;
    check_disp("abort_start", 7'h7F, 7'h7F, 7'd0, 1'b0, 1'b0);

    // Start with pause held: load, then PAUSE, no counting
    pause = 1'b1;
    pulse_start(7'd23);
    check_disp("sp_load", 7'd2, 7'd3, 7'd23, 1'b1, 1'b0);
    cycles(8);
    check_disp("sp_held", 7'd2, 7'd3, 7'd23, 1'b1, 1'b0);
    pause = 1'b0;

    // Asynchronous reset mid-round
    pulse_start(7'd12);
    cycles(2);
    #2 rst_n = 1'b0;
    #1;
    check_disp("rst_mid", 7'h7F, 7'h7F, 7'd0, 1'b0, 1'b0);
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    check_disp("rst_after", 7'h7F, 7'h7F, 7'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/round_timer.md
Name: round_timer

Overview:
- Game-round countdown timer that drives the two 7-segment digit decoders: a tens digit and a ones digit.
- Counts whole seconds down from a loaded value (0-99) and emits a one-cycle expiry pulse when it reaches zero.
- Presents each digit as a 7-bit code: 7'h00-7'h09 for a digit, 7'h7F for blank.
- Sits between the game controller (start/pause/abort) and the per-digit decoders.

Parameters:
- TICKS_PER_SEC, 50_000_000: clk cycles per counted second; minimum 2. The bench uses small values.
- BLINK_TICKS, 12_500_000: clk cycles per blink half-period. Used only with the optional feature.
- MAX_SECS, 99: ceiling applied to load_secs.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: load load_secs and begin counting
- pause  in  1  level: hold the count while high
- abort  in  1  pulse: return to IDLE and blank the display
- load_secs  in  7  round length in seconds, unsigned; values above MAX_SECS clamp to MAX_SECS
- tens_code  out  7  tens digit code to the decoder (0-9, or 7'h7F for blank)
- ones_code  out  7  ones digit code to the decoder (0-9, or 7'h7F for blank)
- running  out  1  high in RUN and PAUSE
- expired  out  1  one-cycle pulse on the clk edge where the count reaches 0
- secs_left  out  7  remaining seconds, binary

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- All outputs are registered.
- Reset values: state=IDLE, secs_left=0, tens_code=7'h7F, ones_code=7'h7F, running=0, expired=0, prescaler=0, blink phase=0.
- Internal count is held as two BCD digits (tens, ones). secs_left is the binary equivalent, tens*10+ones.
- States:
  - IDLE: display blank. start -> RUN, loading the clamped load_secs as BCD and clearing the prescaler.
  - If the clamped load value is 0, go straight to EXPIRED and pulse expired the cycle after start.
  - RUN: the prescaler counts 0..TICKS_PER_SEC-1 and wraps.
  - Each wrap decrements the count. On ones=0 the ones digit wraps to 9 and tens decrements.
  - When the decrement yields 00: go to EXPIRED and pulse expired on that same edge.
  - pause=1 in RUN -> PAUSE.
  - PAUSE: prescaler and count frozen, prescaler value retained. pause=0 -> RUN, resuming mid-second.
  - EXPIRED: shows "00", running=0. start -> RUN with a new load. abort -> IDLE.
- Display:
  - The tens digit is blanked (7'h7F) when tens=0 and state is RUN or PAUSE (leading-zero suppression).
  - The ones digit is always shown in RUN, PAUSE and EXPIRED.
  - Codes update on the same edge as the count.
- Priority on simultaneous inputs: abort > start > pause.
  - start while in RUN or PAUSE restarts immediately with the new load.
  - start and pause high together: load, then enter PAUSE on the next cycle if pause is still high.
- A prescaler wrap in the same cycle as pause rising: the decrement happens; the pause takes effect the next cycle.
- expired never asserts for two consecutive cycles. It does not assert on abort.
- Reset asserted mid-round: all state returns to the reset values immediately, with no expiry pulse.

Optional Feature:
- Macro ROUND_TIMER_BLINK_EN.
- Defined: in EXPIRED, both digits toggle between "00" and 7'h7F every BLINK_TICKS cycles. The "00" phase comes first on entry, and the blink counter is cleared on entry.
- Not defined: EXPIRED shows a steady "00" and the BLINK_TICKS parameter is unused.

Decomposition:
- Shared package game_pkg holds:
  - BLANK_CODE = 7'h7F
  - the state enum (IDLE, RUN, PAUSE, EXPIRED)
  - MAX_SECS_DEFAULT
- One sub-module, tick_prescaler, with inputs clk, rst_n, enable and clear, and output a one-cycle tick pulse, parameterised by TICKS_PER_SEC.
- The same tick_prescaler is instantiated for blink timing under the macro.

Test Plan (all scenarios use TICKS_PER_SEC=4):
- Reset: hold rst_n=0 -> tens_code=7'h7F, ones_code=7'h7F, running=0, expired=0. Release, idle 10 cycles -> outputs unchanged.
- Load 12, start -> display 1,2. After 4 cycles 1,1. At the 10→9 transition tens becomes 7'h7F and ones=9. At 48 cycles after start, expired pulses once and the display shows 0,0.
- load_secs=120, start -> secs_left=99, display 9,9. load_secs=0, start -> EXPIRED next cycle, one expired pulse.
- Load 5, run 6 cycles, pause 20 cycles -> secs_left held at 4 with the display frozen. Release pause -> next decrement comes 2 cycles later, giving total elapsed ticks of 8.
- abort mid-run at secs_left=3 -> IDLE next cycle, both codes 7'h7F, no expired pulse. Simultaneous abort+start -> IDLE.
- With ROUND_TIMER_BLINK_EN and BLINK_TICKS=3: after expiry the codes alternate 0,0 / 7F,7F every 3 cycles until start.
